// File: rtl/tx_ffe_driver.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tx_ffe_driver: 3-tap FFE line driver with saturation, idle, coef shadow.  |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module tx_ffe_driver #(
   parameter real SWING        = 1.0,
   parameter real VMAX         = 1.2,
   parameter real C_PRE_INIT   = -0.1,
   parameter real C_MAIN_INIT  = 0.8,
   parameter real C_POST_INIT  = -0.1,
   parameter int  IDLE_TIMEOUT = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       data_in,
   input  logic       data_valid,
   input  logic       coef_wr,
   input  logic [1:0] coef_sel,
   input  real        coef_val,
   input  logic       coef_commit,
   output logic       coef_ack,
   output logic       coef_err,
   output real        driver_out,
   output logic       out_valid,
   output logic       clip
);

   localparam int C_CNT_W = $clog2(IDLE_TIMEOUT + 1);
   localparam logic [C_CNT_W-1:0] C_TIMEOUT = C_CNT_W'(IDLE_TIMEOUT);

   typedef enum logic [0:0] {
      S_IDLE   = 1'b0,
      S_ACTIVE = 1'b1
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic [C_CNT_W-1:0] r_idle_cnt;
   logic [C_CNT_W-1:0] w_cnt_inc;
   logic               w_timeout;

   real r_h0, r_h1;
   real r_c_pre, r_c_main, r_c_post;
   real r_s_pre, r_s_main, r_s_post;
   real w_sym, w_y, w_y_sat;
   logic w_clip;

   assign w_cnt_inc = r_idle_cnt + 1'b1;

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   // A valid edge always wins over the idle timeout.
   always_comb begin
      w_state_nxt = r_state;
      w_timeout   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (data_valid) w_state_nxt = S_ACTIVE;
         end
         S_ACTIVE: begin
            if (!data_valid && (w_cnt_inc == C_TIMEOUT)) begin
               w_state_nxt = S_IDLE;
               w_timeout   = 1'b1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_sym   = data_in ? SWING : -SWING;
      w_y     = r_c_pre * w_sym + r_c_main * r_h0 + r_c_post * r_h1;
      w_y_sat = w_y;
      w_clip  = 1'b0;
      if (w_y > VMAX) begin
         w_y_sat = VMAX;
         w_clip  = 1'b1;
      end else if (w_y < -VMAX) begin
         w_y_sat = -VMAX;
         w_clip  = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_h0       <= 0.0;
         r_h1       <= 0.0;
         r_idle_cnt <= '0;
         r_c_pre    <= C_PRE_INIT;
         r_c_main   <= C_MAIN_INIT;
         r_c_post   <= C_POST_INIT;
         r_s_pre    <= C_PRE_INIT;
         r_s_main   <= C_MAIN_INIT;
         r_s_post   <= C_POST_INIT;
         driver_out <= 0.0;
         out_valid  <= 1'b0;
         clip       <= 1'b0;
         coef_ack   <= 1'b0;
         coef_err   <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         clip      <= 1'b0;
         coef_ack  <= coef_commit;
         coef_err  <= coef_wr && (coef_sel == 2'd3);

         // Commit samples the shadow before any same-edge write lands.
         if (coef_commit) begin
            r_c_pre  <= r_s_pre;
            r_c_main <= r_s_main;
            r_c_post <= r_s_post;
         end
         if (coef_wr) begin
            case (coef_sel)
               2'd0:    r_s_pre  <= coef_val;
               2'd1:    r_s_main <= coef_val;
               2'd2:    r_s_post <= coef_val;
               default: ;
            endcase
         end

         case (r_state)
            S_IDLE: begin
               if (data_valid) begin
                  r_h1       <= r_h0;
                  r_h0       <= w_sym;
                  r_idle_cnt <= '0;
               end
            end
            S_ACTIVE: begin
               if (data_valid) begin
                  driver_out <= w_y_sat;
                  out_valid  <= 1'b1;
                  clip       <= w_clip;
                  r_h1       <= r_h0;
                  r_h0       <= w_sym;
                  r_idle_cnt <= '0;
               end else if (w_timeout) begin
                  driver_out <= 0.0;
                  r_h0       <= 0.0;
                  r_h1       <= 0.0;
                  r_idle_cnt <= '0;
               end else begin
                  r_idle_cnt <= w_cnt_inc;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_tx_ffe_driver.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_tx_ffe_driver: directed self-checking bench for tx_ffe_driver.         |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module tb_tx_ffe_driver;

   logic       clk;
   logic       r_rst;
   logic       r_data_in;
   logic       r_data_valid;
   logic       r_coef_wr;
   logic [1:0] r_coef_sel;
   real        r_coef_val;
   logic       r_coef_commit;
   logic       w_coef_ack;
   logic       w_coef_err;
   real        w_driver_out;
   logic       w_out_valid;
   logic       w_clip;

   int r_total;
   int r_bad;

   tx_ffe_driver u_dut (
      .clk         (clk),
      .rst         (r_rst),
      .data_in     (r_data_in),
      .data_valid  (r_data_valid),
      .coef_wr     (r_coef_wr),
      .coef_sel    (r_coef_sel),
      .coef_val    (r_coef_val),
      .coef_commit (r_coef_commit),
      .coef_ack    (w_coef_ack),
      .coef_err    (w_coef_err),
      .driver_out  (w_driver_out),
      .out_valid   (w_out_valid),
      .clip        (w_clip)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input real obs, input real exp);
      real d;
      r_total++;
      d = obs - exp;
      if (d < 0.0) d = -d;
      if (d > 1.0e-9) begin
         r_bad++;
         $display("FAIL %s: got %f expected %f", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic b);
      r_data_in    = b;
      r_data_valid = 1'b1;
      tick();
      r_data_valid = 1'b0;
   endtask

   task automatic chk_out(input string tag, input real ov, input real v, input real cl);
      chk({tag, "_ov"}, $itor(w_out_valid), ov);
      chk({tag, "_out"}, w_driver_out, v);
      chk({tag, "_clip"}, $itor(w_clip), cl);
   endtask

   initial begin
      r_total       = 0;
      r_bad         = 0;
      r_rst         = 1'b1;
      r_data_in     = 1'b0;
      r_data_valid  = 1'b0;
      r_coef_wr     = 1'b0;
      r_coef_sel    = 2'd0;
      r_coef_val    = 0.0;
      r_coef_commit = 1'b0;
      tick();
      tick();
      chk_out("rst", 0.0, 0.0, 0.0);
      chk("rst_ack", $itor(w_coef_ack), 0.0);
      chk("rst_err", $itor(w_coef_err), 0.0);
      r_rst = 1'b0;

      // First bit primes history only; then 0.7 and 0.8.
      send(1'b1); chk_out("b1", 0.0, 0.0, 0.0);
      send(1'b1); chk_out("b2", 1.0, 0.7, 0.0);
      send(1'b0); chk_out("b3", 1.0, 0.8, 0.0);
      tick();     chk_out("gap", 0.0, 0.8, 0.0);

      // Alternating stream settles to -sym.
      send(1'b1); chk_out("alt0", 1.0, -1.0, 0.0);
      send(1'b0); chk_out("alt1", 1.0, 1.0, 0.0);
      send(1'b1); chk_out("alt2", 1.0, -1.0, 0.0);
      send(1'b0); chk_out("alt3", 1.0, 1.0, 0.0);

      // Three idle cycles: hold, stay active.
      tick(); tick(); tick();
      chk_out("idle3", 0.0, 1.0, 0.0);
      send(1'b1); chk_out("after3", 1.0, -1.0, 0.0);

      // Four idle cycles: return to idle with cleared history.
      tick(); tick(); tick();
      chk_out("idle3b", 0.0, -1.0, 0.0);
      tick();
      chk_out("idle4", 0.0, 0.0, 0.0);
      send(1'b1); chk_out("re1", 0.0, 0.0, 0.0);
      send(1'b1); chk_out("re2", 1.0, 0.7, 0.0);

      // Main tap 1.5 -> y = 1.3, clipped to VMAX.
      r_coef_wr = 1'b1; r_coef_sel = 2'd1; r_coef_val = 1.5;
      tick();
      r_coef_wr = 1'b0;
      chk("wr_ack", $itor(w_coef_ack), 0.0);
      r_coef_commit = 1'b1;
      tick();
      r_coef_commit = 1'b0;
      chk("cm_ack", $itor(w_coef_ack), 1.0);
      tick();
      chk("cm_ack_end", $itor(w_coef_ack), 0.0);
      send(1'b1); chk_out("sat0", 1.0, 1.2, 1.0);
      send(1'b1); chk_out("sat1", 1.0, 1.2, 1.0);
      send(1'b1); chk_out("sat2", 1.0, 1.2, 1.0);

      // Reset mid-stream ignores valid/commit/err inputs and restores taps.
      r_rst = 1'b1; r_data_valid = 1'b1; r_data_in = 1'b1;
      r_coef_commit = 1'b1; r_coef_wr = 1'b1; r_coef_sel = 2'd3;
      tick();
      r_rst = 1'b0; r_data_valid = 1'b0; r_coef_commit = 1'b0; r_coef_wr = 1'b0;
      chk_out("mrst", 0.0, 0.0, 0.0);
      chk("mrst_ack", $itor(w_coef_ack), 0.0);
      chk("mrst_err", $itor(w_coef_err), 0.0);

      // Simultaneous write and commit: commit takes the old shadow.
      r_coef_wr = 1'b1; r_coef_sel = 2'd1; r_coef_val = 0.5; r_coef_commit = 1'b1;
      tick();
      r_coef_wr = 1'b0; r_coef_commit = 1'b0;
      chk("sim_ack", $itor(w_coef_ack), 1.0);
      send(1'b1); chk_out("sim1", 0.0, 0.0, 0.0);
      send(1'b1); chk_out("sim2", 1.0, 0.7, 0.0);
      r_coef_commit = 1'b1;
      tick();
      r_coef_commit = 1'b0;
      chk("cm2_ack", $itor(w_coef_ack), 1.0);
      send(1'b1); chk_out("new_main", 1.0, 0.3, 0.0);

      // Invalid tap select: error pulse, nothing else changes.
      r_coef_wr = 1'b1; r_coef_sel = 2'd3; r_coef_val = 9.0;
      tick();
      r_coef_wr = 1'b0;
      chk("err1", $itor(w_coef_err), 1.0);
      chk_out("err1", 0.0, 0.3, 0.0);
      tick();
      chk("err_end", $itor(w_coef_err), 0.0);

      // Back-to-back commits with data flowing; taps unchanged by bad write.
      r_coef_commit = 1'b1;
      send(1'b1);
      chk("bb_ack0", $itor(w_coef_ack), 1.0);
      chk_out("bb0", 1.0, 0.3, 0.0);
      send(1'b1);
      r_coef_commit = 1'b0;
      chk("bb_ack1", $itor(w_coef_ack), 1.0);
      chk_out("bb1", 1.0, 0.3, 0.0);
      tick();
      chk("bb_ack2", $itor(w_coef_ack), 0.0);
      chk_out("bb2", 0.0, 0.3, 0.0);

      $display("test done: total=%0d bad=%0d", r_total, r_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/tx_ffe_driver.md
# tx_ffe_driver

Transmit-side feed-forward equalizer and line driver for the analog TX path. It maps the serial bit stream to ±SWING symbols and applies a 3-tap FIR (pre-cursor, main, post-cursor) so the channel and the receive-side equalizer/slicer see a pre-compensated waveform. It produces a `real` line value with saturation, and manages electrical idle and runtime coefficient updates. It sits between the serializer and the channel model.

## Interface
- `SWING`, 1.0: symbol magnitude; bit 1 maps to +SWING, bit 0 to −SWING.
- `VMAX`, 1.2: output saturation magnitude.
- `C_PRE_INIT`, −0.1: reset value of the pre-cursor tap.
- `C_MAIN_INIT`, 0.8: reset value of the main tap.
- `C_POST_INIT`, −0.1: reset value of the post-cursor tap.
- `IDLE_TIMEOUT`, 4: number of consecutive invalid cycles in ACTIVE before the block returns to IDLE.
- `clk`  in  1  clock; all state updates on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `data_in`  in  1  serial bit.
- `data_valid`  in  1  `data_in` is accepted on this edge.
- `coef_wr`  in  1  write `coef_val` into the shadow tap selected by `coef_sel`.
- `coef_sel`  in  2  0 = pre, 1 = main, 2 = post, 3 = invalid.
- `coef_val`  in  real  tap value.
- `coef_commit`  in  1  copy all shadow taps into the active taps.
- `coef_ack`  out  1  one-cycle pulse on the edge after a commit.
- `coef_err`  out  1  one-cycle pulse on the edge after a write with `coef_sel` = 3.
- `driver_out`  out  real  equalized line value.
- `out_valid`  out  1  `driver_out` was updated on this edge.
- `clip`  out  1  one-cycle pulse; `driver_out` was saturated on this edge.

## Operation
- **Symbol mapping:** sym = `data_in` ? +SWING : −SWING.
- **History registers:** h0 (newest), h1. Both reset to 0.0; an unfilled history contributes 0.
- **FIR:** y = c_pre·sym + c_main·h0 + c_post·h1.
  - The main cursor is the symbol accepted on the previous valid edge.
  - The pre-cursor is the current (future) symbol.
- **Saturation:**
  - y > VMAX: `driver_out` = VMAX and `clip` = 1.
  - y < −VMAX: `driver_out` = −VMAX and `clip` = 1.
  - Otherwise `driver_out` = y.
- **State machine:**
  - IDLE: `driver_out` = 0.0, `out_valid` = 0. A valid edge shifts in sym (h1←h0, h0←sym), emits no output, and goes to ACTIVE.
  - ACTIVE, valid edge: register y computed from the pre-shift h0/h1, then shift; `out_valid` = 1; idle counter ← 0.
  - ACTIVE, invalid edge: hold `driver_out`; `out_valid` = 0; idle counter +1.
  - ACTIVE, idle counter reaches IDLE_TIMEOUT: go to IDLE on that edge; h0 = h1 = 0.0; `driver_out` = 0.0.
- **Coefficients:**
  - A write updates only the shadow tap.
  - A commit copies shadow to active. The new taps are used from the edge after the commit edge onward; the commit edge itself uses the old taps.
  - Commit is legal in any state.
  - Shadow taps reset to the INIT values.
- **Simultaneous `coef_wr` and `coef_commit`:** the commit copies the pre-write shadow. The write lands in shadow only and is applied by the next commit.
- **`coef_sel` = 3:** no register changes; `coef_err` pulses.

## Timing
- **Reset values:** `driver_out` = 0.0; `out_valid`, `clip`, `coef_ack`, `coef_err` = 0; state IDLE; idle counter 0; active and shadow taps = INIT values.
- **Reset mid-stream:** everything returns to reset values on that edge; all other inputs are ignored on that edge.
- **Latency:** a bit accepted at valid edge k is the main cursor of the output registered at the next valid edge. It is never output before that edge.
- **Valid pulses:** `out_valid` is high only for the cycle after an ACTIVE valid edge. No valid edge ever produces a gap-free duplicate output.
- **Clip:** `clip` is coincident with `out_valid`.
- **Handshake pulses:** `coef_ack` and `coef_err` are single-cycle. Back-to-back commits give back-to-back acks.
- **Timeout boundary:** a valid edge on the same cycle the idle counter would reach IDLE_TIMEOUT takes priority, so the block stays ACTIVE and the counter clears.

## Test plan
- Reset, then bits 1, 1, 0 on consecutive valid cycles:
  - 1st bit: no output.
  - 2nd bit: `driver_out` = 0.7.
  - 3rd bit: `driver_out` = 0.8.
  - `out_valid` high after the 2nd and 3rd edges only.
- Alternating 1010… stream: steady-state `driver_out` alternates exactly between −1.0 and +1.0; `clip` stays 0.
- Write main tap = 1.5, commit, then a constant stream of 1s:
  - `coef_ack` pulses once.
  - Steady-state y = 1.3, so `driver_out` = 1.2 with `clip` = 1 on every valid output.
- Simultaneous write (main tap = 0.5) and commit:
  - Active main tap stays 0.8.
  - A second commit applies 0.5.
- Write with `coef_sel` = 3: `coef_err` pulses and the output is unchanged.
- Drop `data_valid` in ACTIVE:
  - For 3 cycles: `driver_out` holds and there is no IDLE transition.
  - For 4 cycles: `driver_out` = 0.0 and the history clears. The next first bit produces no output. Asserting `rst` mid-stream gives the same return to reset values.
